// File: rtl/music_player.sv
// Beat sequencer and phase-accumulator square-wave generator for the tone ROM / buzzer path.
// Optional NOTE_GAP_EN macro mutes the tail of every beat so repeated notes are articulated.
module music_player #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BEAT_FREQ    = 8,
  parameter int SONG_LEN     = 60,
  parameter int SILENCE_FREQ = 20000,
  parameter int GAP_CYCLES   = CLK_FREQ / 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [31:0] tone,
  output logic [7:0]  beat_num,
  output logic        audio_out,
  output logic        playing,
  output logic        done
);

  localparam int BEAT_TICKS = CLK_FREQ / BEAT_FREQ;
  localparam int CNT_W      = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BEAT_TICKS - 1);
  localparam logic [7:0]  LAST_BEAT = 8'(SONG_LEN - 1);
  localparam logic [32:0] CLK_F33   = 33'(CLK_FREQ);
  localparam logic [32:0] INC_MAX   = 33'(CLK_FREQ - 1);

  if (SONG_LEN < 1 || SONG_LEN > 256 || GAP_CYCLES < 0 || BEAT_TICKS < 1) begin : g_param_check
    $error("music_player: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [32:0]       r_acc;
  logic [7:0]        r_beat_num;
  logic              r_audio;
  logic              r_done;
  logic              w_beat_end;
  logic              w_song_end;
  logic              w_rest;
  logic              w_gap;
  logic              w_wrap;
  logic [32:0]       w_inc;
  logic [32:0]       w_sum;

  // Twice the tone frequency, capped so the accumulator wraps at most once per cycle.
  function automatic logic [32:0] clamp_inc(input logic [31:0] t);
    logic [32:0] dbl;
    dbl = {t, 1'b0};
    return (dbl >= CLK_F33) ? INC_MAX : dbl;
  endfunction

  assign w_inc  = clamp_inc(tone);
  assign w_sum  = r_acc + w_inc;
  assign w_wrap = (w_sum >= CLK_F33);
  assign w_rest = (tone == 32'(SILENCE_FREQ)) || (tone == 32'd0);

`ifdef NOTE_GAP_EN
  localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_TICKS - GAP_CYCLES);
  assign w_gap = (r_beat_cnt >= GAP_START);
`else
  assign w_gap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_beat_end   = 1'b0;
    w_song_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_next_state = S_PLAY;
      end
      S_PLAY: begin
        w_beat_end = (r_beat_cnt == LAST_TICK);
        if (stop) begin
          w_next_state = S_IDLE;
        end else if (w_beat_end && (r_beat_num == LAST_BEAT) && !loop_en) begin
          w_next_state = S_IDLE;
          w_song_end   = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
      r_beat_num <= '0;
      r_audio    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_song_end;
      if (r_state != S_PLAY || stop) begin
        r_beat_cnt <= '0;
        r_acc      <= '0;
        r_beat_num <= '0;
        r_audio    <= 1'b0;
      end else if (w_beat_end) begin
        r_beat_cnt <= '0;
        r_acc      <= '0;
        r_audio    <= 1'b0;
        // Last beat wraps to 0 both on loop and on natural end (IDLE shows beat 0).
        r_beat_num <= (r_beat_num == LAST_BEAT) ? 8'd0 : r_beat_num + 8'd1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (w_rest || w_gap) begin
          r_acc   <= '0;
          r_audio <= 1'b0;
        end else if (w_wrap) begin
          r_acc   <= w_sum - CLK_F33;
          r_audio <= ~r_audio;
        end else begin
          r_acc   <= w_sum;
        end
      end
    end
  end

  assign beat_num  = r_beat_num;
  assign audio_out = r_audio;
  assign playing   = (r_state == S_PLAY);
  assign done      = r_done;

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player at CLK_FREQ=1000, BEAT_FREQ=10 (100-cycle beats), SONG_LEN=4.
module tb_music_player;

  localparam int CLK_FREQ     = 1000;
  localparam int BEAT_FREQ    = 10;
  localparam int SONG_LEN     = 4;
  localparam int SILENCE_FREQ = 20000;
  localparam int GAP_CYCLES   = 10;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en;
  logic [31:0] tone;
  logic [7:0]  beat_num;
  logic        audio_out, playing, done;
  logic [31:0] tone_tbl [4];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign tone = (beat_num < 8'd4) ? tone_tbl[beat_num[1:0]] : 32'd0;

  music_player #(
    .CLK_FREQ(CLK_FREQ), .BEAT_FREQ(BEAT_FREQ), .SONG_LEN(SONG_LEN),
    .SILENCE_FREQ(SILENCE_FREQ), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .tone(tone), .beat_num(beat_num), .audio_out(audio_out),
    .playing(playing), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected audio_out for tone=250 after the km-th cycle of a beat (km = 1..100).
  function automatic logic exp_audio(input int km);
`ifdef NOTE_GAP_EN
    if (km > 90) return 1'b0;
`endif
    return logic'((km >> 1) & 1);
  endfunction

  task automatic set_all(input logic [31:0] t);
    for (int i = 0; i < 4; i++) tone_tbl[i] = t;
  endtask

  task automatic begin_song();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    set_all(32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({audio_out, playing, done} !== 3'b000 || beat_num !== 8'd0) begin
        n_err++;
        $display("FAIL reset cyc=%0d: got a=%b p=%b d=%b b=%0d expected all 0", i, audio_out, playing, done, beat_num);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_vec++;
      if ({audio_out, playing, done} !== 3'b000 || beat_num !== 8'd0) begin
        n_err++;
        $display("FAIL idle cyc=%0d: got a=%b p=%b d=%b b=%0d expected all 0", i, audio_out, playing, done, beat_num);
      end
    end
  endtask

  task automatic test_pitch();
    int   rises;
    int   exp_rises;
    logic prev;
    set_all(32'd250);
    loop_en = 1'b1;
    begin_song();
    n_vec++;
    if (playing !== 1'b1 || beat_num !== 8'd0) begin
      n_err++;
      $display("FAIL pitch_start: got p=%b b=%0d expected p=1 b=0", playing, beat_num);
    end
`ifdef NOTE_GAP_EN
    exp_rises = 23;
`else
    exp_rises = 25;
`endif
    rises = 0;
    prev  = audio_out;
    for (int k = 1; k <= 200; k++) begin
      step();
      n_vec++;
      if (audio_out !== exp_audio(((k - 1) % 100) + 1)) begin
        n_err++;
        $display("FAIL pitch_audio k=%0d: got %b expected %b", k, audio_out, exp_audio(((k - 1) % 100) + 1));
      end
      n_vec++;
      if (beat_num !== 8'(k / 100)) begin
        n_err++;
        $display("FAIL pitch_beat k=%0d: got %0d expected %0d", k, beat_num, k / 100);
      end
      if (k <= 100 && audio_out && !prev) rises++;
      prev = audio_out;
    end
    n_vec++;
    if (rises !== exp_rises) begin
      n_err++;
      $display("FAIL pitch_rises: got %0d expected %0d", rises, exp_rises);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_vec++;
    if (playing !== 1'b0) begin
      n_err++;
      $display("FAIL pitch_stop: got p=%b expected 0", playing);
    end
  endtask

  task automatic test_song_end();
    int done_cnt;
    set_all(32'd250);
    loop_en  = 1'b0;
    done_cnt = 0;
    begin_song();
    for (int k = 1; k <= 400; k++) begin
      start = (k == 150);
      step();
      start = 1'b0;
      if (done === 1'b1) done_cnt++;
      n_vec++;
      if (done !== (k == 400) || playing !== (k < 400)) begin
        n_err++;
        $display("FAIL end_flags k=%0d: got d=%b p=%b expected d=%b p=%b", k, done, playing, k == 400, k < 400);
      end
      n_vec++;
      if (beat_num !== ((k < 400) ? 8'(k / 100) : 8'd0)) begin
        n_err++;
        $display("FAIL end_beat k=%0d: got %0d expected %0d", k, beat_num, (k < 400) ? k / 100 : 0);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) done_cnt++;
      n_vec++;
      if (playing !== 1'b0 || audio_out !== 1'b0) begin
        n_err++;
        $display("FAIL end_idle i=%0d: got p=%b a=%b expected 0 0", i, playing, audio_out);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL end_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_loop_rest();
    logic ea;
    set_all(32'd250);
    tone_tbl[1] = 32'd20000;
    loop_en = 1'b1;
    begin_song();
    for (int k = 1; k <= 500; k++) begin
      step();
      ea = (((k - 1) / 100) % 4 == 1) ? 1'b0 : exp_audio(((k - 1) % 100) + 1);
      n_vec++;
      if (audio_out !== ea) begin
        n_err++;
        $display("FAIL loop_audio k=%0d: got %b expected %b", k, audio_out, ea);
      end
      n_vec++;
      if (beat_num !== 8'((k / 100) % 4) || done !== 1'b0 || playing !== 1'b1) begin
        n_err++;
        $display("FAIL loop_beat k=%0d: got b=%0d d=%b p=%b expected b=%0d d=0 p=1", k, beat_num, done, playing, (k / 100) % 4);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_stop_collision();
    set_all(32'd250);
    loop_en = 1'b1;
    begin_song();
    for (int k = 1; k <= 250; k++) step();
    n_vec++;
    if (audio_out !== exp_audio(50) || beat_num !== 8'd2) begin
      n_err++;
      $display("FAIL prestop: got a=%b b=%0d expected a=%b b=2", audio_out, beat_num, exp_audio(50));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_vec++;
    if ({playing, audio_out, done} !== 3'b000 || beat_num !== 8'd0) begin
      n_err++;
      $display("FAIL stop: got p=%b a=%b d=%b b=%0d expected all 0", playing, audio_out, done, beat_num);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (done !== 1'b0 || playing !== 1'b0) begin
        n_err++;
        $display("FAIL stop_idle i=%0d: got d=%b p=%b expected 0 0", i, done, playing);
      end
    end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (playing !== 1'b0 || audio_out !== 1'b0) begin
        n_err++;
        $display("FAIL collide i=%0d: got p=%b a=%b expected 0 0", i, playing, audio_out);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    set_all(32'd250);
    loop_en = 1'b1;
    begin_song();
    for (int k = 1; k <= 150; k++) step();
    n_vec++;
    if (beat_num !== 8'd1 || audio_out !== exp_audio(50) || playing !== 1'b1) begin
      n_err++;
      $display("FAIL prereset: got b=%0d a=%b p=%b expected b=1 a=%b p=1", beat_num, audio_out, playing, exp_audio(50));
    end
    rst = 1'b1;
    step();
    n_vec++;
    if ({audio_out, playing, done} !== 3'b000 || beat_num !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid: got a=%b p=%b d=%b b=%0d expected all 0", audio_out, playing, done, beat_num);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({audio_out, playing, done} !== 3'b000 || beat_num !== 8'd0) begin
        n_err++;
        $display("FAIL reset_after i=%0d: got a=%b p=%b d=%b b=%0d expected all 0", i, audio_out, playing, done, beat_num);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pitch();
    test_song_end();
    test_loop_rest();
    test_stop_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
